noc_pkt_buffer: RTL and testbench

NOC_PKT_BUFFER -- requirements
Module: noc_pkt_buffer

---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_ram_2p.sv | 27 ++
 rtl/noc_pkt_buffer.sv | 105 ++++++++++
 tb/tb_noc_pkt_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared word format and defaults for the NoC packet buffer.
// A stored entry is the first-word flag on top of the 64-bit data word.
package noc_pkg;

   localparam int WORD_W    = 64;
   localparam int DEPTH_DEF = 16;

   typedef logic [WORD_W:0] noc_word_t;

   function automatic noc_word_t pack_word(input logic first, input logic [WORD_W-1:0] data);
      return {first, data};
   endfunction

endpackage

// File: rtl/noc_ram_2p.sv
// DEPTH x 65 storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking in the parent makes stale data invisible.
module noc_ram_2p
   import noc_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  noc_word_t     wdata,
   input  logic [AW-1:0] raddr,
   output noc_word_t     rdata
);

   noc_word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/noc_pkt_buffer.sv
// Show-ahead packet word buffer with registered almost-full backpressure,
// packet counting and a sticky overflow flag.
module noc_pkt_buffer
   import noc_pkg::*;
#(
   parameter int DEPTH        = DEPTH_DEF,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pushin,
   input  logic                       firstin,
   input  logic [WORD_W-1:0]          din,
   output logic                       stopin,
   output logic                       pushout,
   output logic                       firstout,
   output logic [WORD_W-1:0]          dout,
   input  logic                       stopout,
   output logic [$clog2(DEPTH):0]     word_cnt,
   output logic [7:0]                 pkt_cnt,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic [7:0]    pkt_cnt_q;
   logic          open_q;
   logic          ovf_q;
   logic          stopin_q;
   logic          pop;
   logic          accept;
   noc_word_t     head;

   assign pushout = (cnt_q != '0);
   assign pop     = pushout & ~stopout;
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign accept  = pushin & ((cnt_q != FULL_CNT) | pop);

   always_comb begin
      cnt_nxt = cnt_q;
      case ({accept, pop})
         2'b10:   cnt_nxt = cnt_q + CW'(1);
         2'b01:   cnt_nxt = cnt_q - CW'(1);
         default: cnt_nxt = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt_q     <= '0;
         pkt_cnt_q <= '0;
         open_q    <= 1'b0;
         ovf_q     <= 1'b0;
         stopin_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_nxt;
         stopin_q <= (cnt_nxt >= AFULL_LVL);
         if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (pushin && !accept) begin
            ovf_q <= 1'b1;
         end
         // A new header closes the previously open packet.
         if (accept && firstin) begin
            open_q <= 1'b1;
            if (open_q) begin
               pkt_cnt_q <= pkt_cnt_q + 8'd1;
            end
         end
      end
   end

   noc_ram_2p #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (accept & ~reset),
      .waddr (wr_ptr),
      .wdata (pack_word(firstin, din)),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign dout     = pushout ? head[WORD_W-1:0] : '0;
   assign firstout = pushout & head[WORD_W];
   assign word_cnt = cnt_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign ovf      = ovf_q;
   assign stopin   = stopin_q;

endmodule

// File: tb/tb_noc_pkt_buffer.sv
// Directed scenarios plus randomized traffic against a queue-based model of the buffer.
module tb_noc_pkt_buffer;

   localparam int DEPTH        = 16;
   localparam int AFULL_MARGIN = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pushin;
   logic        firstin;
   logic [63:0] din;
   logic        stopin;
   logic        pushout;
   logic        firstout;
   logic [63:0] dout;
   logic        stopout;
   logic [4:0]  word_cnt;
   logic [7:0]  pkt_cnt;
   logic        ovf;

   int tests = 0;
   int fails = 0;

   noc_pkt_buffer #(
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (AFULL_MARGIN)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pushin   (pushin),
      .firstin  (firstin),
      .din      (din),
      .stopin   (stopin),
      .pushout  (pushout),
      .firstout (firstout),
      .dout     (dout),
      .stopout  (stopout),
      .word_cnt (word_cnt),
      .pkt_cnt  (pkt_cnt),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of {first, data} entries and a few scalars.
   logic [64:0] mq[$];
   logic [7:0]  m_pkt = '0;
   bit          m_ovf = 0;
   bit          m_open = 0;
   bit          m_stopin = 0;
   bit          model_valid = 0;
   bit          m_pop;
   bit          m_acc;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_pkt       = '0;
         m_ovf       = 0;
         m_open      = 0;
         m_stopin    = 0;
         model_valid = 1;
      end else if (model_valid) begin
         m_pop = (mq.size() != 0) && !stopout;
         m_acc = pushin && ((mq.size() < DEPTH) || m_pop);
         if (m_pop) void'(mq.pop_front());
         if (m_acc) begin
            mq.push_back({firstin, din});
            if (firstin) begin
               if (m_open) m_pkt = m_pkt + 8'd1;
               m_open = 1;
            end
         end else if (pushin) begin
            m_ovf = 1;
         end
         m_stopin = (DEPTH - mq.size()) <= AFULL_MARGIN;
      end
   end

   always @(negedge clk) begin
      logic [63:0] e_dout;
      logic        e_first;
      logic        e_push;
      if (model_valid) begin
         e_push  = (mq.size() != 0);
         e_dout  = e_push ? mq[0][63:0] : 64'h0;
         e_first = e_push ? mq[0][64] : 1'b0;
         tests++;
         if (pushout !== e_push || dout !== e_dout || firstout !== e_first ||
             word_cnt !== 5'(mq.size()) || pkt_cnt !== m_pkt || ovf !== m_ovf ||
             stopin !== m_stopin) begin
            fails++;
            $display("FAIL model t=%0t: got push=%b first=%b dout=%h cnt=%0d pkt=%0d ovf=%b stopin=%b expected push=%b first=%b dout=%h cnt=%0d pkt=%0d ovf=%b stopin=%b",
                     $time, pushout, firstout, dout, word_cnt, pkt_cnt, ovf, stopin,
                     e_push, e_first, e_dout, mq.size(), m_pkt, m_ovf, m_stopin);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic psh, input logic fst,
                      input logic [63:0] d, input logic stp);
      reset   = rst;
      pushin  = psh;
      firstin = fst;
      din     = d;
      stopout = stp;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; pushin = 1'b0; firstin = 1'b0; din = '0; stopout = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pushout", 64'(pushout), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_cnt", 64'(word_cnt), 64'd0);
      chk("rst_stopin", 64'(stopin), 64'd0);

      // single word show-ahead
      cyc(0, 1, 1, 64'h0706050403020100, 0);
      chk("sw_pushout", 64'(pushout), 64'd1);
      chk("sw_firstout", 64'(firstout), 64'd1);
      chk("sw_dout", dout, 64'h0706050403020100);
      cyc(0, 0, 0, 64'h0, 0);
      chk("sw_cnt", 64'(word_cnt), 64'd0);

      // fill to almost full, then the two words allowed after stopin
      for (int i = 0; i < 14; i++) cyc(0, 1, 0, 64'h1000 + 64'(i), 1);
      chk("af_stopin", 64'(stopin), 64'd1);
      chk("af_cnt14", 64'(word_cnt), 64'd14);
      for (int i = 14; i < 16; i++) cyc(0, 1, 0, 64'h1000 + 64'(i), 1);
      chk("full_cnt", 64'(word_cnt), 64'd16);
      chk("full_ovf", 64'(ovf), 64'd0);

      // overflow while stalled, then drain in order
      cyc(0, 1, 0, 64'hDEAD, 1);
      chk("ovf_set", 64'(ovf), 64'd1);
      chk("ovf_cnt", 64'(word_cnt), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), dout, 64'h1000 + 64'(i));
         cyc(0, 0, 0, 64'h0, 0);
      end
      chk("drain_cnt", 64'(word_cnt), 64'd0);
      chk("drain_ovf_sticky", 64'(ovf), 64'd1);

      // full with simultaneous push and pop
      cyc(1, 0, 0, 64'h0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 64'h2000 + 64'(i), 1);
      cyc(0, 1, 0, 64'h2010, 0);
      chk("pp_cnt", 64'(word_cnt), 64'd16);
      chk("pp_ovf", 64'(ovf), 64'd0);
      chk("pp_head", dout, 64'h2001);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, 64'h0, 0);

      // three 8-word packets, then a fourth header closes the third
      cyc(1, 0, 0, 64'h0, 0);
      for (int i = 0; i < 24; i++) cyc(0, 1, (i % 8) == 0, 64'h3000 + 64'(i), (i % 3) == 0);
      chk("pkt_before", 64'(pkt_cnt), 64'd2);
      cyc(0, 1, 1, 64'h3018, 0);
      chk("pkt_three", 64'(pkt_cnt), 64'd3);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 64'h0, 0);

      // reset mid-transfer
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 64'h4000 + 64'(i), 1);
      cyc(1, 1, 1, 64'h4005, 0);
      chk("mr_pushout", 64'(pushout), 64'd0);
      chk("mr_cnt", 64'(word_cnt), 64'd0);
      chk("mr_stopin", 64'(stopin), 64'd0);
      chk("mr_dout", dout, 64'd0);

      // randomized traffic with varying stall density
      for (int ph = 0; ph < 4; ph++) begin
         int stall_pct;
         stall_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 85 : 30;
         for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 20,
                {$urandom, $urandom},
                $urandom_range(0, 99) < stall_pct);
         end
      end
      cyc(0, 0, 0, 64'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
